// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with glitch-filtered clock, frame checks
// and a first-word-fall-through byte FIFO with valid/ready handshake.
module ps2_rx_fifo #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 10000,
   parameter int DEPTH          = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ps2_clk,
   input  logic                   ps2_data,
   output logic [7:0]             rx_data,
   output logic                   rx_valid,
   input  logic                   rx_ready,
   output logic [$clog2(DEPTH):0] fill_level,
   output logic                   parity_err,
   output logic                   frame_err,
   output logic                   overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(FILTER_LEN);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;

   logic [1:0]    csync_q, csync_d, dsync_q, dsync_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          fclk_q, fclk_d, fold_q, fold_d, fall_q, fall_d;
   logic [1:0]    state_q, state_d;
   logic [2:0]    bcnt_q, bcnt_d;
   logic [7:0]    sr_q, sr_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          bit_in, push, pop, full, wr_en;

   // Filter counter only advances while the synchronised level disagrees with fclk.
   always_comb begin
      csync_d = {csync_q[0], ps2_clk};
      dsync_d = {dsync_q[0], ps2_data};
      fcnt_d  = (csync_q[1] == fclk_q || fcnt_q == FMAX) ? '0 : fcnt_q + 1'b1;
      fclk_d  = (csync_q[1] != fclk_q && fcnt_q == FMAX) ? csync_q[1] : fclk_q;
      fold_d  = fclk_q;
      fall_d  = fold_q & ~fclk_q;
      bit_in  = dsync_q[1];
   end

   // Idle counter holds cycles since the last fall; 0 means IDLE.
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      sr_d    = sr_q;
      par_d   = par_q;
      tmo_d   = '0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      push    = 1'b0;
      if (state_q == IDLE) begin
         state_d = (fall_q && !bit_in) ? DATA : IDLE;
         bcnt_d  = '0;
         tmo_d   = (fall_q && !bit_in) ? TW'(1) : '0;
         ferr_d  = fall_q && bit_in;
      end else if (fall_q) begin
         tmo_d = TW'(1);
         if (state_q == DATA) begin
            sr_d    = {bit_in, sr_q[7:1]};
            bcnt_d  = bcnt_q + 3'd1;
            state_d = (bcnt_q == 3'd7) ? PARITY : DATA;
         end else if (state_q == PARITY) begin
            par_d   = bit_in;
            state_d = STOP;
         end else begin
            state_d = IDLE;
            tmo_d   = '0;
            ferr_d  = !bit_in;
            perr_d  = bit_in && !(^{sr_q, par_q});
            push    = bit_in && (^{sr_q, par_q});
         end
      end else if (tmo_q == TMAX) begin
         state_d = IDLE;
         ferr_d  = 1'b1;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   // A simultaneous pop frees the full slot, so the push still lands.
   always_comb begin
      pop   = rx_valid && rx_ready;
      full  = cnt_q == (AW+1)'(DEPTH);
      wr_en = push && (!full || pop);
      ovf_d = push && full && !pop;
      mem_d = mem_q;
      if (wr_en) mem_d[wr_q] = sr_q;
      wr_d  = wr_q + AW'(wr_en);
      rd_d  = rd_q + AW'(pop);
      cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csync_q <= 2'b11;
         dsync_q <= 2'b11;
         fcnt_q  <= '0;
         fclk_q  <= 1'b1;
         fold_q  <= 1'b1;
         fall_q  <= 1'b0;
         state_q <= IDLE;
         bcnt_q  <= '0;
         sr_q    <= '0;
         par_q   <= 1'b0;
         tmo_q   <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovf_q   <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         csync_q <= csync_d;
         dsync_q <= dsync_d;
         fcnt_q  <= fcnt_d;
         fclk_q  <= fclk_d;
         fold_q  <= fold_d;
         fall_q  <= fall_d;
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         sr_q    <= sr_d;
         par_q   <= par_d;
         tmo_q   <= tmo_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ovf_q   <= ovf_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) mem_q <= mem_d;

   assign rx_valid   = cnt_q != '0;
   assign rx_data    = rx_valid ? mem_q[rd_q] : 8'h00;
   assign fill_level = cnt_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign overflow   = ovf_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed bench for ps2_rx_fifo with a small PS/2 bus driver and
// a pulse/pop monitor; expected values are hand-computed per scenario.
module tb_ps2_rx_fifo;
   localparam int F = 8, T = 300, D = 4, H = 25;

   logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, parity_err, frame_err, overflow;
   logic [2:0] fill_level;
   int         checks = 0, errors = 0, cyc = 0, t_fall = 0;
   int         perr_n = 0, ferr_n = 0, ovf_n = 0, vcnt = 0, ferr_cyc = -1, multi_n = 0;
   logic [7:0] popq [$];

   ps2_rx_fifo #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .fill_level(fill_level), .parity_err(parity_err), .frame_err(frame_err),
      .overflow(overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Sampled after the bench drive so rx_ready here is the value the next edge uses.
   always begin
      @(negedge clk);
      #2;
      perr_n += int'(parity_err);
      ferr_n += int'(frame_err);
      ovf_n  += int'(overflow);
      vcnt   += int'(rx_valid);
      if (frame_err) ferr_cyc = cyc;
      if (int'(parity_err) + int'(frame_err) + int'(overflow) > 1) multi_n++;
      if (rx_valid && rx_ready) popq.push_back(rx_data);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input int nbits, input logic par_flip,
                             input logic stop, input int glitch_bit, input logic pop_stop);
      logic [10:0] f;
      f = {stop, ~^b ^ par_flip, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         if (i == glitch_bit) begin
            step(5);
            ps2_clk = 1'b0;
            step(F - 1);
            ps2_clk = 1'b1;
            step(H - 5 - (F - 1));
         end else step(H);
         ps2_clk = 1'b0;
         t_fall  = cyc;
         for (int k = 1; k <= H; k++) begin
            step(1);
            if (pop_stop && i == 10) rx_ready = (k == F + 3);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      step(H);
   endtask

   task automatic test_reset;
      step(4);
      checks += 4;
      if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
      if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_data); end
      if (fill_level !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill_level); end
      if ({parity_err, frame_err, overflow} !== 3'b000) begin
         errors++; $display("FAIL reset_err got %b exp 000", {parity_err, frame_err, overflow});
      end
      rst = 1'b0;
      step(5);
   endtask

   task automatic test_single;
      int v0, e0;
      v0 = vcnt; e0 = perr_n + ferr_n + ovf_n;
      popq.delete();
      rx_ready = 1'b1;
      send_frame(8'h1C, 11, 1'b0, 1'b1, -1, 1'b0);
      checks += 3;
      if (popq.size() != 1 || popq[0] !== 8'h1C) begin
         errors++; $display("FAIL single_data got n=%0d first=%h exp n=1 1c", popq.size(), popq[0]);
      end
      if (vcnt - v0 != 1) begin errors++; $display("FAIL single_valid_cycles got %0d exp 1", vcnt - v0); end
      if (perr_n + ferr_n + ovf_n != e0) begin
         errors++; $display("FAIL single_errs got %0d exp 0", perr_n + ferr_n + ovf_n - e0);
      end
      rx_ready = 1'b0;
   endtask

   task automatic test_order;
      logic [7:0] exp_b [3];
      exp_b = '{8'h1C, 8'h29, 8'h32};
      popq.delete();
      for (int i = 0; i < 3; i++) send_frame(exp_b[i], 11, 1'b0, 1'b1, -1, 1'b0);
      checks += 3;
      if (fill_level !== 3'd3) begin errors++; $display("FAIL order_fill got %0d exp 3", fill_level); end
      if (rx_valid !== 1'b1) begin errors++; $display("FAIL order_valid got %b exp 1", rx_valid); end
      if (rx_data !== 8'h1C) begin errors++; $display("FAIL order_head got %h exp 1c", rx_data); end
      rx_ready = 1'b1;
      step(10);
      rx_ready = 1'b0;
      checks += 3;
      if (popq.size() != 3) begin errors++; $display("FAIL order_count got %0d exp 3", popq.size()); end
      else for (int i = 0; i < 3; i++)
         if (popq[i] !== exp_b[i]) begin
            errors++; $display("FAIL order_byte%0d got %h exp %h", i, popq[i], exp_b[i]);
         end
      if (fill_level !== 3'd0) begin errors++; $display("FAIL order_drained got %0d exp 0", fill_level); end
      if (rx_data !== 8'h00) begin errors++; $display("FAIL order_empty_data got %h exp 00", rx_data); end
   endtask

   task automatic test_errors;
      int p0, f0;
      p0 = perr_n; f0 = ferr_n;
      send_frame(8'h21, 11, 1'b1, 1'b1, -1, 1'b0);
      checks += 3;
      if (perr_n - p0 != 1) begin errors++; $display("FAIL parity_pulse got %0d exp 1", perr_n - p0); end
      if (ferr_n != f0) begin errors++; $display("FAIL parity_noframe got %0d exp 0", ferr_n - f0); end
      if (fill_level !== 3'd0) begin errors++; $display("FAIL parity_fill got %0d exp 0", fill_level); end
      send_frame(8'h5A, 11, 1'b0, 1'b0, -1, 1'b0);
      checks += 3;
      if (ferr_n - f0 != 1) begin errors++; $display("FAIL stop_pulse got %0d exp 1", ferr_n - f0); end
      if (perr_n - p0 != 1) begin errors++; $display("FAIL stop_noparity got %0d exp 0", perr_n - p0 - 1); end
      if (fill_level !== 3'd0) begin errors++; $display("FAIL stop_fill got %0d exp 0", fill_level); end
   endtask

   task automatic test_timeout;
      int f0;
      f0 = ferr_n;
      popq.delete();
      rx_ready = 1'b1;
      send_frame(8'h5A, 5, 1'b0, 1'b1, -1, 1'b0);
      step(T + F + 20);
      checks += 2;
      if (ferr_n - f0 != 1) begin errors++; $display("FAIL timeout_pulse got %0d exp 1", ferr_n - f0); end
      if (ferr_cyc - t_fall != F + 3 + T) begin
         errors++; $display("FAIL timeout_delay got %0d exp %0d", ferr_cyc - t_fall, F + 3 + T);
      end
      send_frame(8'h5A, 11, 1'b0, 1'b1, -1, 1'b0);
      checks += 2;
      if (popq.size() != 1 || popq[0] !== 8'h5A) begin
         errors++; $display("FAIL timeout_next got n=%0d first=%h exp n=1 5a", popq.size(), popq[0]);
      end
      if (ferr_n - f0 != 1) begin errors++; $display("FAIL timeout_next_err got %0d exp 1", ferr_n - f0); end
      rx_ready = 1'b0;
   endtask

   task automatic test_overflow;
      logic [7:0] exp_b [5];
      int o0;
      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      o0 = ovf_n;
      popq.delete();
      for (int i = 0; i < 5; i++) send_frame(exp_b[i], 11, 1'b0, 1'b1, -1, 1'b0);
      checks += 2;
      if (fill_level !== 3'd4) begin errors++; $display("FAIL ovf_fill got %0d exp 4", fill_level); end
      if (ovf_n - o0 != 1) begin errors++; $display("FAIL ovf_pulse got %0d exp 1", ovf_n - o0); end
      rx_ready = 1'b1;
      step(10);
      rx_ready = 1'b0;
      checks += 1;
      if (popq.size() != 4 || popq[3] !== 8'h44) begin
         errors++; $display("FAIL ovf_drain got n=%0d last=%h exp n=4 44", popq.size(), popq[popq.size()-1]);
      end
      o0 = ovf_n;
      popq.delete();
      for (int i = 0; i < 4; i++) send_frame(exp_b[i], 11, 1'b0, 1'b1, -1, 1'b0);
      send_frame(exp_b[4], 11, 1'b0, 1'b1, -1, 1'b1);
      checks += 3;
      if (ovf_n != o0) begin errors++; $display("FAIL pushpop_ovf got %0d exp 0", ovf_n - o0); end
      if (fill_level !== 3'd4) begin errors++; $display("FAIL pushpop_fill got %0d exp 4", fill_level); end
      if (popq.size() != 1) begin errors++; $display("FAIL pushpop_onepop got %0d exp 1", popq.size()); end
      rx_ready = 1'b1;
      step(10);
      rx_ready = 1'b0;
      checks += 1;
      if (popq.size() != 5) begin errors++; $display("FAIL pushpop_count got %0d exp 5", popq.size()); end
      else for (int i = 0; i < 5; i++)
         if (popq[i] !== exp_b[i]) begin
            errors++; $display("FAIL pushpop_byte%0d got %h exp %h", i, popq[i], exp_b[i]);
         end
   endtask

   task automatic test_glitch;
      int e0;
      e0 = perr_n + ferr_n + ovf_n;
      popq.delete();
      rx_ready = 1'b1;
      send_frame(8'h1C, 11, 1'b0, 1'b1, 3, 1'b0);
      checks += 2;
      if (popq.size() != 1 || popq[0] !== 8'h1C) begin
         errors++; $display("FAIL glitch_data got n=%0d first=%h exp n=1 1c", popq.size(), popq[0]);
      end
      if (perr_n + ferr_n + ovf_n != e0) begin
         errors++; $display("FAIL glitch_errs got %0d exp 0", perr_n + ferr_n + ovf_n - e0);
      end
      rx_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      int e0;
      send_frame(8'h29, 11, 1'b0, 1'b1, -1, 1'b0);
      checks += 1;
      if (fill_level !== 3'd1) begin errors++; $display("FAIL rstmid_prefill got %0d exp 1", fill_level); end
      send_frame(8'hA5, 4, 1'b0, 1'b1, -1, 1'b0);
      rst = 1'b1;
      step(2);
      checks += 4;
      if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", rx_valid); end
      if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h exp 00", rx_data); end
      if (fill_level !== 3'd0) begin errors++; $display("FAIL rstmid_fill got %0d exp 0", fill_level); end
      if ({parity_err, frame_err, overflow} !== 3'b000) begin
         errors++; $display("FAIL rstmid_err got %b exp 000", {parity_err, frame_err, overflow});
      end
      rst = 1'b0;
      step(5);
      e0 = perr_n + ferr_n + ovf_n;
      popq.delete();
      rx_ready = 1'b1;
      send_frame(8'h1C, 11, 1'b0, 1'b1, -1, 1'b0);
      checks += 2;
      if (popq.size() != 1 || popq[0] !== 8'h1C) begin
         errors++; $display("FAIL rstmid_next got n=%0d first=%h exp n=1 1c", popq.size(), popq[0]);
      end
      if (perr_n + ferr_n + ovf_n != e0) begin
         errors++; $display("FAIL rstmid_errs got %0d exp 0", perr_n + ferr_n + ovf_n - e0);
      end
      rx_ready = 1'b0;
   endtask

   initial begin
      test_reset;
      test_single;
      test_order;
      test_errors;
      test_timeout;
      test_overflow;
      test_glitch;
      test_reset_mid;
      checks += 1;
      if (multi_n != 0) begin errors++; $display("FAIL exclusive_pulses got %0d exp 0", multi_n); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with an integrated scancode FIFO, replacing the fixed receive path between `ps2_controller` and `data_control`. It synchronises and glitch-filters the PS/2 lines and assembles 11-bit frames. Each frame is checked for start, odd-parity and stop errors, and aborted on inactivity timeout. Good bytes are buffered in a DEPTH-entry first-word-fall-through FIFO with a valid/ready handshake, so the downstream Morse encoder can stall without losing keystrokes.

## Interface
Parameters:
- `FILTER_LEN`, 8: consecutive equal synchronised samples required before the filtered PS/2 clock changes state (≥2).
- `TIMEOUT_CYCLES`, 10000: maximum `clk` cycles between PS/2 falling edges inside a frame (200 µs at 50 MHz).
- `DEPTH`, 4: FIFO entries, power of two, ≥2.

Ports:
- `clk`  in  1  system clock (50 MHz nominal).
- `rst`  in  1  reset, asynchronous, active-high.
- `ps2_clk`  in  1  PS/2 clock from device, asynchronous.
- `ps2_data`  in  1  PS/2 data from device, asynchronous.
- `rx_data`  out  8  FIFO head byte; 0x00 when empty.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts head this cycle.
- `fill_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `parity_err`  out  1  one-cycle pulse, frame failed the odd-parity check.
- `frame_err`  out  1  one-cycle pulse, bad start bit, bad stop bit or timeout.
- `overflow`  out  1  one-cycle pulse, good byte dropped because the FIFO was full.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
  - The synchronised clock feeds a saturating counter filter. The filtered clock `fclk` takes a new level only after FILTER_LEN consecutive cycles at that level.
  - A falling edge of `fclk` produces a one-cycle `fall` strobe. Synchronised data is sampled on `fall`.
- Frame FSM:
  - IDLE:
    - On `fall` with data 0 (start bit), go to DATA with bit count 0.
    - On `fall` with data 1, pulse `frame_err` and stay in IDLE.
  - DATA: shift in 8 bits, LSB first, one per `fall`. After bit 7, go to PARITY.
  - PARITY: sample the parity bit on `fall`, then go to STOP.
  - STOP: sample the stop bit on `fall`, then go to IDLE and evaluate the frame:
    - Stop bit 0: pulse `frame_err`. Nothing is pushed, and the parity result is ignored.
    - Stop bit 1 and the XOR of 8 data bits plus parity bit is 0 (even count of ones): pulse `parity_err`. Nothing is pushed.
    - Otherwise, issue a push request for the byte.
  - Timeout: in DATA, PARITY or STOP, an idle counter runs and clears on every `fall`. When it reaches TIMEOUT_CYCLES, pulse `frame_err`, discard the partial frame and go to IDLE. In IDLE the counter is held at 0.
- FIFO (DEPTH entries, power-of-two wrapping read/write pointers, occupancy count 0..DEPTH):
  - Pop occurs when `rx_valid && rx_ready`.
  - Push while not full: write the byte at the write pointer.
  - Push while full and no pop in the same cycle: drop the byte and pulse `overflow`.
  - Push and pop in the same cycle, including when full: both occur, the count is unchanged, and no overflow.
  - `rx_ready` while empty has no effect. Pointers and count never wrap incorrectly.
- Reset, at any time including mid-frame:
  - FSM returns to IDLE and the partial frame is discarded.
  - FIFO is emptied and the synchroniser and filter are preset to 1 (bus idle).
  - All outputs are 0: `rx_valid`, `rx_data`, `fill_level` and all error pulses.

## Timing
- Pin-to-`fall` latency: 2 (sync) + FILTER_LEN (filter) + 1 (edge register) `clk` cycles after the PS/2 falling edge.
- The stop-bit `fall` is cycle E:
  - `rx_valid`, `rx_data` and `fill_level` update at E+1.
  - `parity_err`, `frame_err` and `overflow` are high for exactly cycle E+1.
- Pop: the next head appears at the following edge. `rx_data` is registered from the FIFO head with no extra latency (FWFT).
- The timeout pulse occurs TIMEOUT_CYCLES cycles after the last `fall`.
- At most one of `parity_err`, `frame_err` or `overflow` asserts in any cycle.
- Minimum supported PS/2 half-period: FILTER_LEN+4 `clk` cycles.

## Test plan
- Frame 0x1C at 12.5 kHz PS/2 clock (data bits 0,0,1,1,1,0,0,0, parity 0, stop 1), with `rx_ready`=1 → `rx_valid` pulses 1 cycle, `rx_data`=0x1C, no error pulses.
- Frames 0x1C, 0x29, 0x32 with `rx_ready`=0, DEPTH=4 → `fill_level`=3. Then `rx_ready`=1 → bytes read 0x1C, 0x29, 0x32 in order, and `fill_level` returns to 0.
- Frame 0x21 sent with parity 0 → `parity_err` pulse, `fill_level` unchanged. Frame 0x5A with stop bit 0 → `frame_err` pulse, nothing pushed.
- Start bit plus 4 data bits, then `ps2_clk` held high → `frame_err` exactly TIMEOUT_CYCLES cycles after the last `fall`. The following full 0x5A frame is received correctly.
- Five good frames with `rx_ready`=0, DEPTH=4 → `fill_level`=4 and `overflow` pulses on the 5th frame. Repeat with a pop in the same cycle as the 5th push → no overflow, `fill_level` stays 4, and the 5th byte is last in order.
- A ps2_clk low glitch of FILTER_LEN−1 cycles mid-frame is ignored and the byte is correct. Asserting `rst` mid-frame → all outputs are 0, and the next full frame 0x1C is received correctly.
